// File: rtl/alu_pipe_pkg.sv
// Shared types for alu_pipe: opcode encoding, result flags and FSM states.
package alu_pipe_pkg;

  typedef enum logic [3:0] {
    OP_EQ   = 4'b0000,
    OP_LT   = 4'b0001,
    OP_LTU  = 4'b0010,
    OP_GT   = 4'b0011,
    OP_GTU  = 4'b0100,
    OP_ADD  = 4'b0101,
    OP_ADD2 = 4'b0110,
    OP_SUB  = 4'b0111,
    OP_SLL  = 4'b1000,
    OP_SRL  = 4'b1001,
    OP_SRA  = 4'b1010,
    OP_OR   = 4'b1011,
    OP_XOR  = 4'b1100,
    OP_AND  = 4'b1101,
    OP_MUL  = 4'b1110,
    OP_ILL  = 4'b1111
  } alu_op_e;

  typedef struct packed {
    logic zero;
    logic ovf;
    logic neg;
    logic carry;
    logic err;
  } alu_flags_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } alu_state_e;

endpackage

// File: rtl/alu_pipe_mul.sv
// Iterative shift-add unsigned multiplier, one partial-product bit per cycle.
// Exists only when ALU_PIPE_MUL_EN is defined.
`ifdef ALU_PIPE_MUL_EN
module alu_pipe_mul
  import alu_pipe_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] prod_lo,
  output logic             prod_hi_nz
);

  localparam int SHW = $clog2(WIDTH);

  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   mcand;
  logic [SHW-1:0]     cnt;
  logic               busy;
  logic [WIDTH:0]     sum;

  // The multiplier sits in the low half of acc and is consumed LSB-first
  // while the partial product grows into the high half.
  assign sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? mcand : {WIDTH{1'b0}})};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      mcand <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        acc   <= {{WIDTH{1'b0}}, b};
        mcand <= a;
        cnt   <= '0;
        busy  <= 1'b1;
      end else if (busy) begin
        acc <= {sum, acc[WIDTH-1:1]};
        cnt <= cnt + 1'b1;
        if (cnt == SHW'(WIDTH - 1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  assign prod_lo    = acc[WIDTH-1:0];
  assign prod_hi_nz = |acc[2*WIDTH-1:WIDTH];

endmodule
`endif

// File: rtl/alu_pipe.sv
// Handshaked ALU with a registered result/flags stage.
// Define ALU_PIPE_MUL_EN to add the iterative unsigned multiply (opcode 1110).
module alu_pipe
  import alu_pipe_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_res,
  output logic             out_zero,
  output logic             out_ovf,
  output logic             out_neg,
  output logic             out_carry,
  output logic             out_err
);

  localparam int SHW = $clog2(WIDTH);
  localparam int MSB = WIDTH - 1;

  alu_op_e          op;
  logic [SHW-1:0]   shamt;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] alu_res;
  alu_flags_t       alu_flags;
  logic [WIDTH-1:0] res_q;
  alu_flags_t       flags_q;
  alu_state_e       state;
  logic             accept;
  logic             is_mul;

  assign op     = alu_op_e'(in_op);
  assign shamt  = in_b[SHW-1:0];
  assign accept = in_valid && in_ready;

  always_comb begin
    alu_res   = '0;
    alu_flags = '0;
    sum       = '0;
    case (op)
      OP_EQ:  alu_flags.zero = (in_a == in_b);
      OP_LT:  alu_flags.zero = ($signed(in_a) < $signed(in_b));
      OP_LTU: alu_flags.zero = (in_a < in_b);
      OP_GT:  alu_flags.zero = ($signed(in_a) > $signed(in_b));
      OP_GTU: alu_flags.zero = (in_a > in_b);
      OP_ADD, OP_ADD2: begin
        sum             = {1'b0, in_a} + {1'b0, in_b} + {{WIDTH{1'b0}}, in_cin};
        alu_res         = sum[WIDTH-1:0];
        alu_flags.carry = sum[WIDTH];
        alu_flags.ovf   = (in_a[MSB] == in_b[MSB]) && (alu_res[MSB] != in_a[MSB]);
      end
      OP_SUB: begin
        sum             = {1'b0, in_a} + {1'b0, ~in_b} + {{WIDTH{1'b0}}, 1'b1};
        alu_res         = sum[WIDTH-1:0];
        alu_flags.carry = sum[WIDTH];
        alu_flags.ovf   = (in_a[MSB] != in_b[MSB]) && (alu_res[MSB] != in_a[MSB]);
      end
      OP_SLL: alu_res = in_a << shamt;
      OP_SRL: alu_res = in_a >> shamt;
      OP_SRA: alu_res = $signed(in_a) >>> shamt;
      OP_OR:  alu_res = in_a | in_b;
      OP_XOR: alu_res = in_a ^ in_b;
      OP_AND: alu_res = in_a & in_b;
`ifdef ALU_PIPE_MUL_EN
      OP_MUL: alu_res = '0;
`endif
      default: alu_flags.err = 1'b1;
    endcase
    alu_flags.neg = alu_res[MSB];
  end

`ifdef ALU_PIPE_MUL_EN
  logic             mul_done;
  logic [WIDTH-1:0] mul_lo;
  logic             mul_hi_nz;
  alu_flags_t       mul_flags;

  assign is_mul = (op == OP_MUL);

  alu_pipe_mul #(.WIDTH(WIDTH)) u_mul (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (accept && is_mul),
    .a          (in_a),
    .b          (in_b),
    .done       (mul_done),
    .prod_lo    (mul_lo),
    .prod_hi_nz (mul_hi_nz)
  );

  always_comb begin
    mul_flags       = '0;
    mul_flags.neg   = mul_lo[MSB];
    mul_flags.carry = mul_hi_nz;
  end
`else
  assign is_mul = 1'b0;
`endif

  // A consumed result drops out_valid unless a new result loads on the same
  // edge; MUL results load from the multiplier once it reports done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      out_valid <= 1'b0;
      res_q     <= '0;
      flags_q   <= '0;
    end else begin
      if (out_valid && out_ready)
        out_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept && !is_mul) begin
            out_valid <= 1'b1;
            res_q     <= alu_res;
            flags_q   <= alu_flags;
          end
`ifdef ALU_PIPE_MUL_EN
          else if (accept)
            state <= ST_MUL;
`endif
        end
`ifdef ALU_PIPE_MUL_EN
        ST_MUL: begin
          if (mul_done) begin
            out_valid <= 1'b1;
            res_q     <= mul_lo;
            flags_q   <= mul_flags;
            state     <= ST_IDLE;
          end
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (state == ST_IDLE) && (!out_valid || out_ready);
  assign out_res   = res_q;
  assign out_zero  = flags_q.zero;
  assign out_ovf   = flags_q.ovf;
  assign out_neg   = flags_q.neg;
  assign out_carry = flags_q.carry;
  assign out_err   = flags_q.err;

endmodule

// File: tb/tb_alu_pipe.sv
// Randomised bench for alu_pipe against a transaction-level reference model.
// Follows ALU_PIPE_MUL_EN the same way the design does.
module tb_alu_pipe;

  localparam int WIDTH = 32;
`ifdef ALU_PIPE_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_res;
  logic             out_zero, out_ovf, out_neg, out_carry, out_err;

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res),
    .out_zero  (out_zero),
    .out_ovf   (out_ovf),
    .out_neg   (out_neg),
    .out_carry (out_carry),
    .out_err   (out_err)
  );

  int compared   = 0;
  int mismatched = 0;

  // Reference model: held output transaction plus a pending multiply countdown.
  logic        m_valid;
  logic [31:0] m_res;
  logic [4:0]  m_flags;
  int          mul_wait;
  logic [36:0] mul_pend;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Result and flags {res, zero, ovf, neg, carry, err} from the opcode rules.
  function automatic logic [36:0] refOp(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic cin);
    logic [31:0]     r;
    logic            z, o, c, e;
    longint          sa, sb, s;
    longint unsigned u;
    int              amt;
    r = '0; z = 0; o = 0; c = 0; e = 0;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    amt = int'(b % 32);
    case (op)
      4'd0: z = (a == b);
      4'd1: z = (sa < sb);
      4'd2: z = (a < b);
      4'd3: z = (sa > sb);
      4'd4: z = (a > b);
      4'd5, 4'd6: begin
        u = {32'b0, a} + {32'b0, b} + {63'b0, cin};
        r = u[31:0];
        c = u[32];
        s = sa + sb + longint'(cin);
        o = (s != longint'($signed(r)));
      end
      4'd7: begin
        r = a - b;
        c = (a >= b);
        s = sa - sb;
        o = (s != longint'($signed(r)));
      end
      4'd8:  r = a << amt;
      4'd9:  r = a >> amt;
      4'd10: r = (a >> amt) | (a[31] ? ~(32'hFFFF_FFFF >> amt) : 32'h0);
      4'd11: r = a | b;
      4'd12: r = a ^ b;
      4'd13: r = a & b;
      4'd14: begin
        if (MUL_EN) begin
          u = {32'b0, a} * {32'b0, b};
          r = u[31:0];
          c = (u[63:32] != 0);
        end else begin
          e = 1;
        end
      end
      default: e = 1;
    endcase
    return {r, z, o, r[31], c, e};
  endfunction

  task automatic modelReset();
    m_valid  = 1'b0;
    m_res    = '0;
    m_flags  = '0;
    mul_wait = 0;
    mul_pend = '0;
  endtask

  // Drive one cycle of inputs, check the DUT against the model, clock, update model.
  task automatic applyStimulus(input logic v, input logic [3:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic cin, input logic ordy);
    logic exp_ready, fire_out, take;
    in_valid  = v;
    in_op     = op;
    in_a      = a;
    in_b      = b;
    in_cin    = cin;
    out_ready = ordy;
    #1;
    exp_ready = (mul_wait == 0) && (!m_valid || ordy);
    checkOutput("in_ready", in_ready, exp_ready);
    checkOutput("out_valid", out_valid, m_valid);
    if (m_valid) begin
      checkOutput("out_res", out_res, m_res);
      checkOutput("flags", {out_zero, out_ovf, out_neg, out_carry, out_err}, m_flags);
    end
    fire_out = m_valid && ordy;
    take     = v && exp_ready;
    @(posedge clk);
    if (mul_wait > 0) begin
      mul_wait--;
      if (mul_wait == 0) begin
        m_valid = 1'b1;
        {m_res, m_flags} = mul_pend;
      end
    end else begin
      if (fire_out) m_valid = 1'b0;
      if (take) begin
        if (MUL_EN && op == 4'd14) begin
          mul_wait = WIDTH + 1;
          mul_pend = refOp(op, a, b, cin);
        end else begin
          m_valid = 1'b1;
          {m_res, m_flags} = refOp(op, a, b, cin);
        end
      end
    end
    @(negedge clk);
  endtask

  // Single accepted op followed by a fixed-value check of the held result.
  task automatic runDirected(input string tag, input logic [3:0] op, input logic [31:0] a,
                             input logic [31:0] b, input logic cin,
                             input logic [31:0] exp_res, input logic [4:0] exp_flags);
    applyStimulus(1'b1, op, a, b, cin, 1'b1);
    checkOutput({tag, "_res"}, out_res, exp_res);
    checkOutput({tag, "_flags"}, {out_zero, out_ovf, out_neg, out_carry, out_err}, exp_flags);
  endtask

  function automatic logic [31:0] randOperand();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'h7FFF_FFFF;
      3: return 32'hFFFF_FFFF;
      4: return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst_n = 1'b0;
    in_valid = 0; in_op = 0; in_a = 0; in_b = 0; in_cin = 0; out_ready = 0;
    modelReset();
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_valid", out_valid, 1'b0);
    checkOutput("rst_res", out_res, 32'h0);
    checkOutput("rst_flags", {out_zero, out_ovf, out_neg, out_carry, out_err}, 5'b0);
    rst_n = 1'b1;
    #1;
    checkOutput("rst_ready", in_ready, 1'b1);
    @(negedge clk);

    // Directed vectors, back to back at one op per cycle.
    runDirected("add_ovf",  4'd5,  32'h7FFF_FFFF, 32'h1, 1'b0, 32'h8000_0000, 5'b01100);
    runDirected("sub_neg",  4'd7,  32'd5, 32'd7, 1'b0, 32'hFFFF_FFFE, 5'b00100);
    runDirected("sub_pos",  4'd7,  32'd7, 32'd5, 1'b0, 32'h2, 5'b00010);
    runDirected("sra",      4'd10, 32'h8000_0000, 32'h24, 1'b0, 32'hF800_0000, 5'b00100);
    runDirected("sll0",     4'd8,  32'h1234_5678, 32'h40, 1'b0, 32'h1234_5678, 5'b00000);
    runDirected("lt",       4'd1,  32'hFFFF_FFFF, 32'h1, 1'b0, 32'h0, 5'b10000);
    runDirected("ltu",      4'd2,  32'hFFFF_FFFF, 32'h1, 1'b0, 32'h0, 5'b00000);
    runDirected("gt",       4'd3,  32'h1, 32'hFFFF_FFFF, 1'b0, 32'h0, 5'b10000);
    runDirected("eq",       4'd0,  32'd9, 32'd9, 1'b0, 32'h0, 5'b10000);
    runDirected("illegal",  4'd15, 32'd3, 32'd4, 1'b1, 32'h0, 5'b00001);
    runDirected("add_cin",  4'd6,  32'hFFFF_FFFF, 32'h0, 1'b1, 32'h0, 5'b00010);
    runDirected("xor",      4'd12, 32'hF0F0_F0F0, 32'hFFFF_0000, 1'b0, 32'h0F0F_F0F0, 5'b00000);
    if (!MUL_EN)
      runDirected("op14_ill", 4'd14, 32'd3, 32'd4, 1'b0, 32'h0, 5'b00001);

    // Backpressure: result must hold and no new op accepted.
    runDirected("bp_first", 4'd5, 32'd1, 32'd2, 1'b0, 32'd3, 5'b00000);
    for (int i = 0; i < 5; i++)
      applyStimulus(1'b1, 4'd12, $urandom, $urandom, 1'b0, 1'b0);
    checkOutput("bp_hold", out_res, 32'd3);
    runDirected("bp_next", 4'd11, 32'h0F, 32'hF0, 1'b0, 32'hFF, 5'b00000);
    applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b1);

    if (MUL_EN) begin
      applyStimulus(1'b1, 4'd14, 32'h1_0000, 32'h1_0000, 1'b0, 1'b1);
      for (int i = 0; i < WIDTH + 1; i++)
        applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
      checkOutput("mul_valid", out_valid, 1'b1);
      checkOutput("mul_res", out_res, 32'h0);
      checkOutput("mul_flags", {out_zero, out_ovf, out_neg, out_carry, out_err}, 5'b00010);
      applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b1);
      // Abort a second multiply with a reset pulse partway through.
      applyStimulus(1'b1, 4'd14, 32'd1234, 32'd5678, 1'b0, 1'b1);
      for (int i = 0; i < 9; i++)
        applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b1);
      rst_n = 1'b0;
      #1;
      modelReset();
      checkOutput("abort_valid", out_valid, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checkOutput("abort_ready", in_ready, 1'b1);
      for (int i = 0; i < WIDTH + 8; i++)
        applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b1);
    end

    // Randomised traffic with random backpressure.
    for (int i = 0; i < 1500; i++)
      applyStimulus($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)),
                    randOperand(), randOperand(), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 3) != 0);
    for (int i = 0; i < WIDTH + 4; i++)
      applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
